// File: rtl/regfile_pkg.sv
// regfile_pkg: shared ARM64 register-file constants, index type and XZR helper.
package regfile_pkg;
  localparam int ARM64_DATA_W = 64;
  localparam int ARM64_NREGS = 32;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_XZR = 5'd31;
  function automatic logic reg_is_zero(reg_idx_t a);
    return a == REG_XZR;
  endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: resolves NWR write ports into per-register enable/data, highest port wins.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W = ARM64_DATA_W,
  parameter int NREGS  = ARM64_NREGS,
  parameter int NWR    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [NWR-1:0]                 i_we,
  input  logic [NWR*AW-1:0]              i_wa,
  input  logic [NWR*DATA_W-1:0]          i_wd,
  output logic [NREGS-1:0]               o_we,
  output logic [NREGS-1:0][DATA_W-1:0]   o_wd
);
  localparam logic [AW-1:0] XZR = AW'(NREGS - 1);
  // Ascending scan lets a higher-numbered port overwrite a lower one on the same register.
  always_comb begin
    o_we = '0;
    o_wd = '0;
    for (int p = 0; p < NWR; p++)
      if (i_we[p] && i_wa[p*AW +: AW] != XZR) begin
        o_we[i_wa[p*AW +: AW]] = 1'b1;
        o_wd[i_wa[p*AW +: AW]] = i_wd[p*DATA_W +: DATA_W];
      end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported ARM64 register file with XZR and a per-register pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = ARM64_DATA_W,
  parameter int NREGS  = ARM64_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NWR-1:0]         we,
  input  logic [NWR*AW-1:0]      wa,
  input  logic [NWR*DATA_W-1:0]  wd,
  input  logic [NRD*AW-1:0]      ra,
  output logic [NRD*DATA_W-1:0]  rd,
  output logic [NRD-1:0]         rd_pend,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr
);
  localparam logic [AW-1:0] XZR = AW'(NREGS - 1);
  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0]             r_pend;
  logic [NREGS-1:0]             w_we;
  logic [NREGS-1:0][DATA_W-1:0] w_wd;
  logic [NREGS-1:0]             w_alloc;

  regfile_wr_arb #(.DATA_W(DATA_W), .NREGS(NREGS), .NWR(NWR)) u_arb (
    .i_we(we),
    .i_wa(wa),
    .i_wd(wd),
    .o_we(w_we),
    .o_wd(w_wd)
  );

  assign w_alloc = (alloc_en && alloc_addr != XZR) ? NREGS'(1) << alloc_addr : '0;

  // A same-cycle alloc keeps the register pending: it names a newer producer.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= DATA_W'(i);
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) if (w_we[i]) r_regs[i] <= w_wd[i];
      r_pend <= w_alloc | (r_pend & ~w_we);
    end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = ra[r*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd[r*DATA_W +: DATA_W] = (w_a == XZR) ? '0 :
                                    (w_we[w_a] && !reset) ? w_wd[w_a] : r_regs[w_a];
`else
    assign rd[r*DATA_W +: DATA_W] = (w_a == XZR) ? '0 : r_regs[w_a];
`endif
    assign rd_pend[r] = (w_a != XZR) && r_pend[w_a];
  end
endmodule
